// File: rtl/rr_arbiter_4.sv
// Round-robin arbiter for four requesters: registered one-hot grant plus 2-bit mux-select index.
// Optional grant watchdog enabled by defining ARB_TIMEOUT_EN (limit set by MAX_HOLD).
module rr_arbiter_4 #(
  parameter int unsigned RESET_PTR = 0,
  parameter int unsigned MAX_HOLD  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t     state, state_next;
  logic [3:0] gnt_next;
  logic [1:0] idx_next;
  logic [1:0] ptr, ptr_next;
  logic       found;
  logic [1:0] pick;
  logic       hold_expired;

  // Rotating priority search starting at ptr; the 2-bit add wraps 3 -> 0.
  always_comb begin
    logic [1:0] cand;
    found = 1'b0;
    pick  = ptr;
    cand  = ptr;
    for (int unsigned i = 0; i < 4; i++) begin
      cand = ptr + 2'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_next = state;
    gnt_next   = gnt;
    idx_next   = gnt_idx;
    ptr_next   = ptr;
    case (state)
      IDLE: begin
        if (found) begin
          state_next = GRANT;
          gnt_next   = 4'b0001 << pick;
          idx_next   = pick;
          ptr_next   = pick + 2'd1;
        end
      end
      GRANT: begin
        // Release (holder drop or watchdog) wins over any waiting request.
        if (!req[gnt_idx] || hold_expired) begin
          state_next = IDLE;
          gnt_next   = '0;
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      gnt     <= '0;
      gnt_idx <= '0;
      ptr     <= 2'(RESET_PTR);
    end else begin
      state   <= state_next;
      gnt     <= gnt_next;
      gnt_idx <= idx_next;
      ptr     <= ptr_next;
    end
  end

  assign gnt_valid = |gnt;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);

  logic [CNT_W-1:0] hold_cnt, hold_next;
  logic             timeout_next;

  assign hold_expired = (state == GRANT) && req[gnt_idx] && (hold_cnt == CNT_W'(MAX_HOLD));

  always_comb begin
    hold_next    = hold_cnt;
    timeout_next = 1'b0;
    if (state == IDLE) begin
      hold_next = found ? CNT_W'(1) : '0;
    end else if (state_next == IDLE) begin
      hold_next    = '0;
      timeout_next = hold_expired;
    end else begin
      hold_next = hold_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      hold_cnt <= hold_next;
      timeout  <= timeout_next;
    end
  end
`else
  assign hold_expired = 1'b0;
  assign timeout      = 1'b0 & (MAX_HOLD != 0);
`endif

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Scoreboard bench for rr_arbiter_4: a queue-based behavioural model predicts every cycle's outputs.
module tb_rr_arbiter_4;

  localparam int RP = 1;
`ifdef ARB_TIMEOUT_EN
  localparam int MH  = 4;
  localparam bit TMO = 1'b1;
`else
  localparam int MH  = 8;
  localparam bit TMO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  rr_arbiter_4 #(
    .RESET_PTR(RP),
    .MAX_HOLD (MH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .gnt_valid(gnt_valid),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       valid;
    logic       tmo;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: who holds the resource, whose turn is next, how long the grant has lasted.
  int   m_holder = -1;
  int   m_ptr    = RP;
  int   m_idx    = 0;
  int   m_held   = 0;
  bit   m_tmo    = 1'b0;

  function automatic void model_reset();
    m_holder = -1;
    m_ptr    = RP;
    m_idx    = 0;
    m_held   = 0;
    m_tmo    = 1'b0;
  endfunction

  function automatic void model_edge(input logic [3:0] r);
    bit done;
    int c;
    m_tmo = 1'b0;
    if (m_holder < 0) begin
      done = 1'b0;
      for (int k = 0; k < 4; k++) begin
        c = (m_ptr + k) % 4;
        if (!done && r[c]) begin
          done     = 1'b1;
          m_holder = c;
          m_idx    = c;
          m_ptr    = (c + 1) % 4;
          m_held   = 1;
        end
      end
    end else if (!r[m_holder]) begin
      m_holder = -1;
    end else if (TMO && m_held == MH) begin
      m_holder = -1;
      m_tmo    = 1'b1;
    end else begin
      m_held++;
    end
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.gnt   = (m_holder >= 0) ? (4'b0001 << m_holder) : 4'b0000;
    e.idx   = 2'(m_idx);
    e.valid = (m_holder >= 0);
    e.tmo   = m_tmo;
    return e;
  endfunction

  function automatic void chk(input string name, input logic [3:0] act, input logic [3:0] req_val);
    checks++;
    if (act !== req_val) begin
      errors++;
      $display("FAIL %s at %0t: actual=%b required=%b", name, $time, act, req_val);
    end
  endfunction

  // Monitor: compares the oldest prediction against the DUT at each falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("gnt",       gnt,                e.gnt);
        chk("gnt_idx",   {2'b00, gnt_idx},   {2'b00, e.idx});
        chk("gnt_valid", {3'b000, gnt_valid}, {3'b000, e.valid});
        chk("timeout",   {3'b000, timeout},  {3'b000, e.tmo});
      end
    end
  end

  task automatic cycle(input logic [3:0] r);
    req = r;
    @(posedge clk);
    model_edge(r);
    exp_q.push_back(model_out());
    #1;
  endtask

  // Asynchronous reset mid-cycle: the prediction already queued for the coming
  // falling edge becomes the reset values, since outputs clear without a clock.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    model_reset();
    if (exp_q.size() > 0) exp_q[exp_q.size()-1] = model_out();
    else exp_q.push_back(model_out());
    @(posedge clk);
    exp_q.push_back(model_out());
    #1;
    rst = 1'b0;
  endtask

  task automatic run_drop(input logic [3:0] base, input int n, input int hold);
    logic [3:0] r;
    for (int i = 0; i < n; i++) begin
      r = base;
      if (m_holder >= 0 && m_held >= hold) r[m_holder] = 1'b0;
      cycle(r);
    end
  endtask

  initial begin
    logic [3:0] r;
    model_reset();
    @(posedge clk);
    exp_q.push_back(model_out());
    #1;
    rst = 1'b0;

    for (int i = 0; i < 10; i++) cycle(4'b0000);

    for (int i = 0; i < 3; i++) cycle(4'b0100);
    for (int i = 0; i < 3; i++) cycle(4'b0000);

    run_drop(4'b1111, 16, 2);
    for (int i = 0; i < 2; i++) cycle(4'b0000);

    // Grant to idx 2 leaves ptr at 3; 1001 then exercises the 3 -> 0 wrap.
    for (int i = 0; i < 2; i++) cycle(4'b0100);
    cycle(4'b0000);
    run_drop(4'b1001, 9, 2);
    for (int i = 0; i < 2; i++) cycle(4'b0000);

    cycle(4'b0010);
    cycle(4'b0010);
    do_reset();
    run_drop(4'b1111, 10, 2);
    for (int i = 0; i < 2; i++) cycle(4'b0000);

    for (int i = 0; i < 20; i++) cycle(4'b0011);
    for (int i = 0; i < 2; i++) cycle(4'b0000);

    for (int i = 0; i < 400; i++) begin
      r = 4'($urandom);
      if (m_holder >= 0 && $urandom_range(0, 3) != 0) r[m_holder] = 1'b1;
      if ($urandom_range(0, 99) == 0) do_reset();
      else cycle(r);
    end

    for (int i = 0; i < 3; i++) cycle(4'b0000);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: actual=%0d pending required=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
